// File: rtl/note_fetcher.sv
// -----------------------------------------------------------------------------
// note_fetcher
//   Steps through a note chart ROM and fetches one note per beat into a
//   4-entry first-word-fall-through FIFO. The consumer drains the FIFO with
//   a valid/ready handshake. Playback ends at the last chart address, or
//   early once END_ZEROS consecutive rest notes (5'b00000) have been captured.
//
//   Build option: define SONG_LOOP_EN to restart from address 0 at the end of
//   the song instead of stopping; o_song_done then pulses for one cycle per
//   loop.
//
//   Parameters
//     BEAT_DIV  : clock cycles per beat (4..65535)
//     SONG_LEN  : chart entries, last address is SONG_LEN-1 (1..256)
//     END_ZEROS : consecutive rest notes that end the song early (1..15)
//
//   Ports
//     i_clk          : clock, rising edge
//     i_reset        : asynchronous active-high reset
//     i_start        : one-cycle pulse, starts playback at address 0
//     o_rom_addr     : registered note ROM address
//     i_rom_data     : note ROM data, valid one cycle after o_rom_addr changes
//     o_note_valid   : FIFO head holds a note
//     i_note_ready   : consumer takes the head this cycle
//     o_note         : head note lane bits (bit0 = lane 0), 0 when empty
//     o_note_index   : chart address of the head note, 0 when empty
//     o_busy         : high while fetching (not IDLE, not DONE)
//     o_song_done    : high while in DONE (loop build: one-cycle pulse)
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start after reset
// ADDR    | o_rom_addr presented to the ROM
// WAIT    | one cycle of ROM latency
// CAPTURE | hold data until the beat edge with FIFO space, then push
// DONE    | song finished, FIFO keeps draining, start replays
// -----------------------------------------------------------------------------
module note_fetcher #(
  parameter int BEAT_DIV  = 16,
  parameter int SONG_LEN  = 94,
  parameter int END_ZEROS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  output logic [7:0] o_rom_addr,
  input  logic [4:0] i_rom_data,
  output logic       o_note_valid,
  input  logic       i_note_ready,
  output logic [4:0] o_note,
  output logic [7:0] o_note_index,
  output logic       o_busy,
  output logic       o_song_done
);

  localparam logic [15:0] BEAT_LAST = 16'(BEAT_DIV - 1);
  localparam logic [7:0]  ADDR_LAST = 8'(SONG_LEN - 1);
  localparam logic [3:0]  ZRUN_END  = 4'(END_ZEROS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_beat;
  logic [7:0]  r_rom_addr;
  logic [3:0]  r_zrun;

  logic [12:0] r_fifo_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;

  logic        w_idle_like;
  logic        w_busy;
  logic        w_start_ok;
  logic        w_beat_edge;
  logic        w_fifo_full;
  logic        w_fifo_valid;
  logic        w_pop;
  logic        w_push;
  logic [3:0]  w_zrun_nxt;
  logic        w_song_end;
  logic [12:0] w_head;

  assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy       = !w_idle_like;
  assign w_start_ok   = i_start && w_idle_like;
  assign w_beat_edge  = (r_beat == BEAT_LAST);

  assign w_fifo_valid = (r_count != 3'd0);
  assign w_fifo_full  = (r_count == 3'd4);
  assign w_pop        = w_fifo_valid && i_note_ready;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push       = (r_state == S_CAPTURE) && w_beat_edge &&
                        (!w_fifo_full || w_pop);

  // Zero-run including the note being captured now.
  assign w_zrun_nxt   = (i_rom_data == 5'd0) ? (r_zrun + 4'd1) : 4'd0;
  assign w_song_end   = (r_rom_addr == ADDR_LAST) || (w_zrun_nxt >= ZRUN_END);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_push) begin
`ifdef SONG_LOOP_EN
          w_state_nxt = S_ADDR;
`else
          w_state_nxt = w_song_end ? S_DONE : S_ADDR;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
`ifdef SONG_LOOP_EN
  logic r_loop_pulse;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_loop_pulse <= 1'b0;
    end else begin
      r_loop_pulse <= w_push && w_song_end;
    end
  end
`endif

  always_comb begin
    o_busy      = w_busy;
`ifdef SONG_LOOP_EN
    o_song_done = (r_state == S_DONE) || r_loop_pulse;
`else
    o_song_done = (r_state == S_DONE);
`endif
  end

  // ---------------------------------------------------------------------------
  // Beat counter, chart address and zero-run tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_beat     <= '0;
      r_rom_addr <= '0;
      r_zrun     <= '0;
    end else begin
      if (w_start_ok) begin
        r_beat     <= '0;
        r_rom_addr <= '0;
        r_zrun     <= '0;
      end else begin
        if (w_busy) begin
          r_beat <= w_beat_edge ? 16'd0 : (r_beat + 16'd1);
        end
        if (w_push) begin
          if (!w_song_end) begin
            r_rom_addr <= r_rom_addr + 8'd1;
            r_zrun     <= w_zrun_nxt;
          end else begin
`ifdef SONG_LOOP_EN
            r_rom_addr <= '0;
            r_zrun     <= '0;
`else
            // Address holds on the last fetched entry while in DONE.
            r_zrun     <= w_zrun_nxt;
`endif
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 4-entry FWFT FIFO of {index, note}
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= {r_rom_addr, i_rom_data};
        r_wr_ptr             <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = w_fifo_valid ? r_fifo_mem[r_rd_ptr] : 13'd0;
  assign o_note_valid = w_fifo_valid;
  assign o_note       = w_head[4:0];
  assign o_note_index = w_head[12:5];
  assign o_rom_addr   = r_rom_addr;

endmodule

// File: tb/tb_note_fetcher.sv
module tb_note_fetcher;

  localparam int BD    = 4;
  localparam int LEN_A = 3;
  localparam int LEN_B = 256;
  localparam int EZ    = 4;
  localparam int T_MAX = 4000;

`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, ready_a, valid_a, busy_a, done_a;
  logic [7:0] rom_addr_a, index_a;
  logic [4:0] note_a;
  logic [4:0] rom_data_a = '0;

  logic       rst_b, start_b, ready_b, valid_b, busy_b, done_b;
  logic [7:0] rom_addr_b, index_b;
  logic [4:0] note_b;
  logic [4:0] rom_data_b = '0;

  logic [4:0] rom_a [256];
  logic [4:0] rom_b [256];

  note_fetcher #(.BEAT_DIV(BD), .SONG_LEN(LEN_A), .END_ZEROS(EZ)) u_dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_start(start_a),
    .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a),
    .o_note_valid(valid_a), .i_note_ready(ready_a),
    .o_note(note_a), .o_note_index(index_a),
    .o_busy(busy_a), .o_song_done(done_a)
  );

  note_fetcher #(.BEAT_DIV(BD), .SONG_LEN(LEN_B), .END_ZEROS(EZ)) u_dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_start(start_b),
    .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
    .o_note_valid(valid_b), .i_note_ready(ready_b),
    .o_note(note_b), .o_note_index(index_b),
    .o_busy(busy_b), .o_song_done(done_b)
  );

  // Synchronous ROMs: data follows the address by one clock.
  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

  int n_checks = 0;
  int n_pass   = 0;
  int t;
  int pos;
  int last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the song plays addresses 0..end, where end is the last address
  // or the address completing END_ZEROS consecutive rests.
  function automatic int last_index(input logic [4:0] mem [256], input int len, input int endz);
    int run;
    run = 0;
    for (int i = 0; i < len; i++) begin
      run = (mem[i] == 5'd0) ? run + 1 : 0;
      if (run >= endz || i == len - 1) return i;
    end
    return len - 1;
  endfunction

  // One cycle of B: drive ready, score a pop if one happens at the next edge.
  task automatic tick_b(input logic rdy);
    int k;
    ready_b = rdy;
    if (valid_b && rdy) begin
      k = pos % (last_b + 1);
      check("pop_idx_b", index_b, k);
      check("pop_note_b", note_b, rom_b[k[7:0]]);
      pos++;
    end
    @(negedge clk);
    t++;
  endtask

  initial begin
    int last_a, pops, done_cnt, k, run;
    logic [4:0] v;

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;

    for (int i = 0; i < 256; i++) rom_a[i] = 5'($urandom_range(0, 31));
    rom_a[0] = 5'b00001; rom_a[1] = 5'b00100; rom_a[2] = 5'b10000;
    run = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= 90 && i <= 93)                 v = 5'd0;
      else if (i < 90 && (run == EZ - 1 || i == 89)) v = 5'($urandom_range(1, 31));
      else if ($urandom_range(0, 3) == 0)     v = 5'd0;
      else                                    v = 5'($urandom_range(1, 31));
      run = (v == 5'd0) ? run + 1 : 0;
      rom_b[i] = v;
    end
    last_a = last_index(rom_a, LEN_A, EZ);
    last_b = last_index(rom_b, LEN_B, EZ);

    // ---- reset values
    repeat (2) @(negedge clk);
    check("reset_a", {rom_addr_a, valid_a, note_a, index_a, busy_a, done_a}, 0);
    check("reset_b", {rom_addr_b, valid_b, note_b, index_b, busy_b, done_b}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_a", {rom_addr_a, valid_a, note_a, index_a, busy_a, done_a}, 0);
    check("idle_b", {rom_addr_b, valid_b, note_b, index_b, busy_b, done_b}, 0);

    // ---- A: 3-note song, consumer always ready, stray start while busy
    ready_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t = 0; pops = 0; done_cnt = 0;
    while (t < 28) begin
      if (t == 3) check("empty_head_a", {valid_a, note_a, index_a}, 0);
      if (t == 6) begin
        check("busy_mid_a", busy_a, 1);
        start_a = 1'b1;
      end
      if (t == 7) start_a = 1'b0;
      if (done_a) done_cnt++;
      if (valid_a) begin
        k = pops % (last_a + 1);
        check("pop_idx_a", index_a, k);
        check("pop_note_a", note_a, rom_a[k[7:0]]);
        check("pop_time_a", t, BD * (pops + 1));
        pops++;
      end
      @(negedge clk);
      t++;
    end
    check("pop_count_a", pops, LOOP ? (28 - 1) / BD : last_a + 1);
    check("done_cycles_a", done_cnt, LOOP ? 27 / (BD * (last_a + 1)) : 28 - BD * (last_a + 1));
`ifndef SONG_LOOP_EN
    check("end_state_a", {busy_a, done_a, rom_addr_a}, {1'b0, 1'b1, 8'd2});
`endif

    // ---- A: asynchronous reset with notes buffered
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    ready_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_reset_a", {valid_a, index_a, note_a, rom_addr_a, busy_a},
          {1'b1, 8'd0, rom_a[0], (LOOP ? 8'd0 : 8'd2), LOOP});
    #2 rst_a = 1'b1;
    #1 check("async_reset_a", {valid_a, note_a, index_a, rom_addr_a, busy_a, done_a}, 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    check("after_reset_a", {valid_a, note_a, index_a, rom_addr_a, busy_a, done_a}, 0);

    // ---- B: 40-cycle stall, resume, full push+pop, then random backpressure
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    t = 0; pos = 0;
    repeat (40) tick_b(1'b0);
    check("stall_b", {valid_b, index_b, rom_addr_b, busy_b}, {1'b1, 8'd0, 8'd4, 1'b1});
    repeat (4) tick_b(1'b1);
    check("resume_b", {valid_b, index_b, rom_addr_b}, {1'b1, 8'd4, 8'd5});
    while (t < 63) tick_b(1'b0);
    check("full_b", {valid_b, index_b, rom_addr_b}, {1'b1, 8'd4, 8'd8});
    tick_b(1'b1);
    check("full_pushpop_b", {index_b, rom_addr_b}, {8'd5, 8'd9});
    repeat (4) tick_b(1'b0);
    check("full_hold_b", rom_addr_b, 9);
    repeat (4) tick_b(1'b1);
    check("after_drain4_b", {valid_b, index_b}, {1'b1, 8'd9});

`ifdef SONG_LOOP_EN
    while (pos < 2 * (last_b + 1) + 3 && t < T_MAX) tick_b($urandom_range(0, 3) != 0);
    check("b_in_time", t < T_MAX, 1);
`else
    while (!(done_b && !valid_b) && t < T_MAX) tick_b($urandom_range(0, 3) != 0);
    check("b_in_time", t < T_MAX, 1);
    check("pop_count_b", pos, last_b + 1);
    check("end_state_b", {busy_b, done_b, rom_addr_b, valid_b, note_b, index_b},
          {1'b0, 1'b1, 8'(last_b), 1'b0, 5'd0, 8'd0});

    // ---- B: start from DONE replays the chart
    ready_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("restart_b", {busy_b, done_b, rom_addr_b}, {1'b1, 1'b0, 8'd0});
    repeat (BD) @(negedge clk);
    check("restart_head_b", {valid_b, index_b, note_b}, {1'b1, 8'd0, rom_b[0]});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_fetcher.md
NOTE_FETCHER -- requirements
Module: note_fetcher

Interface
REQ-001 SHALL have parameter BEAT_DIV, default 16, meaning clock cycles per beat (one note fetched per beat), legal range 4..65535.
REQ-002 SHALL have parameter SONG_LEN, default 94, meaning number of chart entries; the last address is SONG_LEN-1, legal range 1..256.
REQ-003 SHALL have parameter END_ZEROS, default 4, meaning consecutive 5'b00000 notes that end the song early, legal range 1..15.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins playback from address 0.
REQ-007 rom_addr  output  8  note ROM address, registered.
REQ-008 rom_data  input  5  note ROM data; valid exactly one clk after rom_addr changes.
REQ-009 note_valid  output  1  FIFO head holds a note.
REQ-010 note_ready  input  1  consumer accepts the head this cycle.
REQ-011 note  output  5  FIFO head lane bits; bit0 = lane 0.
REQ-012 note_index  output  8  chart address the head note came from.
REQ-013 busy  output  1  high in any state except IDLE and DONE.
REQ-014 song_done  output  1  high while in DONE.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, WAIT, CAPTURE and DONE.
REQ-016 IDLE->ADDR on start; rom_addr:=0, zero-run counter:=0, beat counter:=0.
REQ-017 ADDR->WAIT after one cycle. WAIT lasts exactly one cycle to cover the 1-cycle ROM latency, then goes to CAPTURE.
REQ-018 In CAPTURE, rom_data SHALL be written to the FIFO, tagged with rom_addr, when the beat counter equals BEAT_DIV-1 and the FIFO is not full; otherwise the FSM stays in CAPTURE.
REQ-019 Beat counter SHALL count 0..BEAT_DIV-1 and wrap whenever the FSM is not in IDLE or DONE.
REQ-020 After a write: if rom_addr==SONG_LEN-1, or the zero-run reaches END_ZEROS including this note, go to DONE; else rom_addr:=rom_addr+1 and go to ADDR.
REQ-021 Zero-run counter SHALL increment on a captured 5'b00000 note and clear on any non-zero note.
REQ-022 Rest notes (00000) SHALL be pushed like any other note.
REQ-023 FIFO SHALL be 4 entries of {index[7:0], note[4:0]}, first-word fall-through.
REQ-024 A pop SHALL occur when note_valid and note_ready are both high.
REQ-025 A simultaneous push and pop when full SHALL be legal and keep the count at 4.
REQ-026 When the FIFO is empty, note and note_index SHALL be 0.
REQ-027 start SHALL be ignored while busy. start in DONE SHALL behave as in IDLE. The FIFO SHALL keep draining in DONE.
REQ-028 If the FIFO is full at the beat edge, the push SHALL wait for the next beat edge with space; no note is dropped.

Reset
REQ-029 Reset SHALL force state IDLE and clear rom_addr, all counters and the FIFO.
REQ-030 During and after reset, all outputs SHALL read 0 until the next start.
REQ-031 Reset mid-song SHALL discard all buffered notes.

Configuration
REQ-032 When macro SONG_LOOP_EN is defined, end of song SHALL set rom_addr:=0, clear the zero-run counter and go to ADDR instead of DONE; song_done SHALL then pulse high for one cycle per loop.
REQ-033 When SONG_LOOP_EN is undefined, end of song SHALL enter DONE as in REQ-020.

Verification
REQ-034 BEAT_DIV=4; ROM[0..2]=00001,00100,10000; SONG_LEN=3; note_ready=1 -> notes popped in that order with note_index 0,1,2; song_done high after the third push.
REQ-035 note_ready=0 for 40 cycles, BEAT_DIV=4 -> FIFO holds indexes 0..3 and rom_addr stalls at 4; on release, index 4 is pushed on the next beat edge with no gap in indexes.
REQ-036 ROM[90..93]=00000 with END_ZEROS=4, SONG_LEN=256 -> DONE after the push of index 93; rest notes are delivered.
REQ-037 Reset asserted while 3 notes are buffered -> note_valid=0, rom_addr=0 and state IDLE in the same cycle, asynchronously.
REQ-038 Start pulsed while busy -> no effect; with SONG_LOOP_EN defined and SONG_LEN=3 -> note_index sequence 0,1,2,0,1,2 with one song_done pulse per loop.
